// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: a single full-adder cell is stepped over the
// operands LSB-first, one bit per clock, with the carry held in a register.

module full_adder_bh (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);

  always_comb begin
    s = a ^ b ^ cin;
    c = (a & b) | (a & cin) | (b & cin);
  end

endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-2:0] r_acc;

  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_acc_nxt;

  full_adder_bh u_fa (
    .s   (w_fa_s),
    .c   (w_fa_c),
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .cin (r_carry)
  );

  // Accumulator keeps only the WIDTH-1 bits already produced; the bit being
  // computed this cycle is appended at the top so the final edge can publish
  // the complete word directly.
  assign w_acc_nxt = {w_fa_s, r_acc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_carry <= w_fa_c;
          r_acc   <= w_acc_nxt[WIDTH-1:1];
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            sum     <= w_acc_nxt;
            cout    <= w_fa_c;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 scenarios plus an exhaustive
// sweep of a WIDTH=2 instance.

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; glitch >= 0 re-asserts start with new operands at
  // that RUN cycle, which must be ignored.
  task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                     input logic ic, input logic [7:0] es, input logic ec, input int glitch);
    int lat;
    int nbusy;
    int extra;
    @(negedge clk);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0;
    nbusy = 0;
    while (!done8 && lat < 40) begin
      if (busy8) nbusy++;
      if (lat == glitch) begin
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    if (busy8) nbusy++;
    chk({tag, "/done_seen"}, 32'(done8), 32'd1);
    chk({tag, "/latency"}, lat, 8);
    chk({tag, "/busy_cycles"}, nbusy, 9);
    chk({tag, "/sum"}, 32'(sum8), 32'(es));
    chk({tag, "/cout"}, 32'(cout8), 32'(ec));
    @(negedge clk);
    chk({tag, "/done_drop"}, 32'(done8), 32'd0);
    chk({tag, "/busy_drop"}, 32'(busy8), 32'd0);
    if (glitch >= 0) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done8) extra++;
      end
      chk({tag, "/extra_done"}, extra, 0);
    end
  endtask

  task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ic);
    int lat;
    int e;
    @(negedge clk);
    a2 = ia; b2 = ib; cin2 = ic; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = int'(ia) + int'(ib) + int'(ic);
    chk($sformatf("w2 a=%0d b=%0d c=%0d", ia, ib, ic),
        done2 ? {29'd0, cout2, sum2} : 32'hFFFF_FFFF, 32'(e));
  endtask

  initial begin
    int ndone;
    int npulse;
    int last;
    int unstable;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset/busy", 32'(busy8), 32'd0);
    chk("reset/done", 32'(done8), 32'd0);
    chk("reset/sum", 32'(sum8), 32'd0);
    chk("reset/cout", 32'(cout8), 32'd0);
    chk("reset/w2", {29'd0, done2, cout2, busy2}, 32'd0);

    op8("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, -1);
    op8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
    op8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1);
    op8("t3", 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 3);

    // Asynchronous reset in the middle of a RUN cycle.
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4/busy_before", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t4/busy", 32'(busy8), 32'd0);
    chk("t4/done", 32'(done8), 32'd0);
    chk("t4/sum", 32'(sum8), 32'd0);
    chk("t4/cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("t4/no_partial", ndone, 0);
    op8("t4b", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, -1);

    // start held high: back-to-back operations at the minimum interval.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; start8 = 1'b1;
    npulse = 0;
    last = -1;
    unstable = 0;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      if (done8) begin
        if (last >= 0) chk("t5/interval", t - last, 10);
        chk("t5/sum", 32'(sum8), 32'h31);
        npulse++;
        last = t;
      end else if (npulse > 0 && (sum8 !== 8'h31 || cout8 !== 1'b0)) begin
        unstable++;
      end
    end
    start8 = 1'b0;
    chk("t5/pulses", npulse, 4);
    chk("t5/stable", unstable, 0);
    repeat (12) @(negedge clk);

    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++)
          op2(2'(ia), 2'(ib), 1'(ic));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
